alu_operand_entry: RTL and testbench

- Upstream input stage for the 6-bit ALU display. It turns slide switches and two push-buttons into registered operands a, b and opcode op.
- The user enters A, then B, then the opcode through a button-driven state machine. Outputs feed the ALU display block's a/b/op inputs directly.
- Push-buttons are synchronised and debounced inside the block. Switch values are sampled only at capture instants.

---
 rtl/alu_operand_entry_pkg.sv | 11 +
 rtl/alu_operand_entry_button_debouncer.sv | 33 +++
 rtl/alu_operand_entry.sv | 59 +++++
 tb/tb_alu_operand_entry.sv | 127 ++++++++++++
 4 files changed

// File: rtl/alu_operand_entry_pkg.sv
// alu_operand_entry_pkg: shared state encoding and widths for operand entry
package alu_operand_entry_pkg;
  localparam int OPND_W = 6;
  localparam int OP_W = 3;
  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ENTER_OP = 2'd2,
    SHOW = 2'd3
  } state_t;
endpackage

// File: rtl/alu_operand_entry_button_debouncer.sv
// button_debouncer: two-flop synchroniser, counter debouncer and one-cycle press pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input logic clk_100MHz,
  input logic rst_n,
  input logic btn_raw,
  output logic level,
  output logic press
);
  logic s1, s2, db, db_q;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      db_q <= db;
      if (s2 == db) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db <= s2;
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
  assign level = db;
  assign press = db & ~db_q;
endmodule

// File: rtl/alu_operand_entry.sv
// alu_operand_entry: button-driven entry of ALU operands a, b and opcode op
module alu_operand_entry
  import alu_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input logic clk_100MHz,
  input logic rst_n,
  input logic [OPND_W-1:0] sw,
  input logic [OP_W-1:0] sw_op,
  input logic btn_enter,
  input logic btn_clear,
  output logic [OPND_W-1:0] a,
  output logic [OPND_W-1:0] b,
  output logic [OP_W-1:0] op,
  output logic [1:0] stage,
  output logic ready
);
  state_t state, state_d;
  logic ent_p, clr_p, unused_ent_lvl, unused_clr_lvl;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ent (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .btn_raw(btn_enter),
    .level(unused_ent_lvl),
    .press(ent_p)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .btn_raw(btn_clear),
    .level(unused_clr_lvl),
    .press(clr_p)
  );
  // SHOW + 1 wraps to ENTER_A; clear overrides a coincident enter
  always_comb state_d = clr_p ? ENTER_A : ent_p ? state_t'(state + 2'd1) : state;
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      state <= ENTER_A;
      ready <= 1'b0;
      a <= '0;
      b <= '0;
      op <= '0;
    end else begin
      state <= state_d;
      ready <= state_d == SHOW;
      if (clr_p) begin
        a <= '0;
        b <= '0;
        op <= '0;
      end else if (ent_p) begin
        if (state == ENTER_A) a <= sw;
        if (state == ENTER_B) b <= sw;
        if (state == ENTER_OP) op <= sw_op;
      end
    end
  assign stage = state;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: directed self-checking bench with DEBOUNCE_CYCLES=4
module tb_alu_operand_entry;
  logic clk_100MHz = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] sw = '0;
  logic [2:0] sw_op = '0;
  logic btn_enter = 1'b0;
  logic btn_clear = 1'b0;
  logic [5:0] a, b;
  logic [2:0] op;
  logic [1:0] stage;
  logic ready;
  int n_cmp = 0;
  int n_err = 0;
  alu_operand_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n(rst_n),
    .sw(sw),
    .sw_op(sw_op),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .a(a),
    .b(b),
    .op(op),
    .stage(stage),
    .ready(ready)
  );
  always #5 clk_100MHz = ~clk_100MHz;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                         input logic [2:0] eo, input logic [1:0] es, input logic er);
    chk({tag, "_a"}, {2'b0, a}, {2'b0, ea});
    chk({tag, "_b"}, {2'b0, b}, {2'b0, eb});
    chk({tag, "_op"}, {5'b0, op}, {5'b0, eo});
    chk({tag, "_stage"}, {6'b0, stage}, {6'b0, es});
    chk({tag, "_ready"}, {7'b0, ready}, {7'b0, er});
  endtask
  task automatic press(input logic ent, input logic clr, input int hold);
    @(negedge clk_100MHz);
    btn_enter = ent;
    btn_clear = clr;
    repeat (hold) @(negedge clk_100MHz);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (10) @(negedge clk_100MHz);
  endtask
  // enter goes high just before edge k; stage must hold through k+5 and move at k+6
  task automatic timed_enter(input string tag, input logic [1:0] pre, input logic [1:0] post);
    @(negedge clk_100MHz);
    btn_enter = 1'b1;
    repeat (6) @(posedge clk_100MHz);
    #1 chk({tag, "_k5"}, {6'b0, stage}, {6'b0, pre});
    @(posedge clk_100MHz);
    #1 chk({tag, "_k6"}, {6'b0, stage}, {6'b0, post});
    @(negedge clk_100MHz);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk_100MHz);
  endtask
  task automatic drive_enter(input logic v, input int n);
    btn_enter = v;
    repeat (n) @(negedge clk_100MHz);
  endtask
  initial begin
    #1 chk_all("reset", 6'd0, 6'd0, 3'd0, 2'd0, 1'b0);
    repeat (3) @(negedge clk_100MHz);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    chk_all("idle", 6'd0, 6'd0, 3'd0, 2'd0, 1'b0);
    sw = 6'b000101;
    timed_enter("cap_a", 2'd0, 2'd1);
    chk("cap_a_val", {2'b0, a}, 8'h05);
    chk("cap_a_ready", {7'b0, ready}, 8'h00);
    sw = 6'b111101;
    timed_enter("cap_b", 2'd1, 2'd2);
    chk("cap_b_val", {2'b0, b}, 8'h3D);
    sw_op = 3'b010;
    sw = 6'h2F;
    timed_enter("cap_op", 2'd2, 2'd3);
    chk_all("show", 6'h05, 6'h3D, 3'd2, 2'd3, 1'b1);
    sw = 6'h11;
    sw_op = 3'd7;
    repeat (5) @(negedge clk_100MHz);
    chk_all("sw_idle", 6'h05, 6'h3D, 3'd2, 2'd3, 1'b1);
    press(1'b1, 1'b0, 8);
    chk_all("wrap", 6'h05, 6'h3D, 3'd2, 2'd0, 1'b0);
    sw = 6'd7;
    press(1'b1, 1'b0, 8);
    chk_all("wrap_a", 6'd7, 6'h3D, 3'd2, 2'd1, 1'b0);
    sw = 6'h2A;
    @(negedge clk_100MHz);
    repeat (6) begin
      drive_enter(1'b1, 3);
      drive_enter(1'b0, 1);
      drive_enter(1'b1, 2);
      drive_enter(1'b0, 1);
    end
    repeat (10) @(negedge clk_100MHz);
    chk_all("bounce", 6'd7, 6'h3D, 3'd2, 2'd1, 1'b0);
    press(1'b1, 1'b0, 10);
    chk_all("bounce_hold", 6'd7, 6'h2A, 3'd2, 2'd2, 1'b0);
    sw_op = 3'd5;
    press(1'b1, 1'b1, 8);
    chk_all("collide", 6'd0, 6'd0, 3'd0, 2'd0, 1'b0);
    sw = 6'd21;
    press(1'b1, 1'b0, 100);
    chk_all("held", 6'd21, 6'd0, 3'd0, 2'd1, 1'b0);
    sw = 6'h11;
    press(1'b1, 1'b0, 8);
    chk_all("repress", 6'd21, 6'h11, 3'd0, 2'd2, 1'b0);
    @(negedge clk_100MHz);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 6'd0, 6'd0, 3'd0, 2'd0, 1'b0);
    repeat (2) @(negedge clk_100MHz);
    rst_n = 1'b1;
    sw = 6'd3;
    timed_enter("post_rst", 2'd0, 2'd1);
    chk("post_rst_a", {2'b0, a}, 8'h03);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
